observer_uart_arbiter: RTL

//  Shares the single UART transmit byte channel between N_REQ message sources inside observer
//  (e.g. button-event reporter, status/heartbeat printer).

---
 rtl/observer_uart_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/observer_uart_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX byte channel.
// An owner keeps the channel until its last byte or an idle timeout.
module observer_uart_arbiter #(
  parameter int N_REQ        = 2,
  parameter int DATA_W       = 8,
  parameter int IDLE_TIMEOUT = 1024,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_grant_valid,
  output logic [IW-1:0]           o_grant_idx,
  output logic                    o_timeout
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              txv_q, txv_d;
  logic [DATA_W-1:0] txd_q, txd_d;
  logic              to_q, to_d;

  logic [IW-1:0]     pick;
  logic              found;
  logic [IW-1:0]     nxt_idx;
  logic              lock;
  logic              can_take;
  logic              own_valid;
  logic              own_last;
  logic [DATA_W-1:0] own_data;
  logic              accept;
  logic              to_hit;

  // Scan rr_q, rr_q+1, ... modulo N_REQ for the first pending request
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign nxt_idx   = (gidx_q == IW'(N_REQ - 1)) ? '0
                                                : gidx_q + IW'(1);
  assign lock      = (state_q == S_LOCK);
  assign can_take  = ~txv_q | i_tx_ready;
  assign own_valid = i_req_valid[gidx_q];
  assign own_last  = i_req_last[gidx_q];
  assign own_data  = i_req_data[int'(gidx_q)*DATA_W +: DATA_W];
  assign accept    = lock & own_valid & can_take;

  always_comb begin
    to_hit = 1'b0;
    if (IDLE_TIMEOUT > 0)
      to_hit = lock & ~own_valid &
               (cnt_q == CW'(IDLE_TIMEOUT - 1));
  end

  always_comb begin
    o_req_ready = '0;
    if (lock) o_req_ready[gidx_q] = can_take;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!lock || accept)
      cnt_d = '0;
    else if (!own_valid && cnt_q != '1)
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    to_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LOCK;
          gidx_d  = pick;
        end
      end
      S_LOCK: begin
        if ((accept && own_last) || to_hit) begin
          state_d = S_IDLE;
          rr_d    = nxt_idx;
          to_d    = to_hit;
        end
      end
    endcase
  end

  // A drained byte may still be pending while re-arbitrating
  always_comb begin
    txv_d = txv_q;
    txd_d = txd_q;
    if (accept) begin
      txv_d = 1'b1;
      txd_d = own_data;
    end else if (i_tx_ready && txv_q) begin
      txv_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      to_q    <= to_d;
    end
  end

  assign o_tx_data     = txd_q;
  assign o_tx_valid    = txv_q;
  assign o_grant_valid = lock;
  assign o_grant_idx   = gidx_q;
  assign o_timeout     = to_q;

endmodule
